// File: rtl/transmitter.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, then a one-cycle cleanup.
// All outputs are registered; RST asynchronously aborts any frame in progress.
module transmitter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tx_DV_in,
    input  logic [7:0] Tx_Byte_in,
    output logic       Tx_Active_out,
    output logic       Tx_Serial_out,
    output logic       Tx_Done_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       tx_byte;

    // NOTE: every register here uses non-blocking assignment so all of them see pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            tx_byte       <= '0;
            Tx_Serial_out <= 1'b1;
            Tx_Active_out <= 1'b0;
            Tx_Done_out   <= 1'b0;
        end else begin
            // NOTE: the done flag defaults low every cycle, so it can only ever be a one-cycle pulse.
            Tx_Done_out <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt       <= '0;
                    bit_idx       <= '0;
                    Tx_Serial_out <= 1'b1;
                    if (Tx_DV_in) begin
                        tx_byte       <= Tx_Byte_in;
                        Tx_Active_out <= 1'b1;
                        Tx_Serial_out <= 1'b0;
                        state         <= START;
                    end
                end

                START: begin
                    if (clk_cnt != LAST_CNT) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt       <= '0;
                        bit_idx       <= '0;
                        Tx_Serial_out <= tx_byte[0];
                        state         <= DATA;
                    end
                end

                DATA: begin
                    if (clk_cnt != LAST_CNT) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            bit_idx       <= bit_idx + 3'd1;
                            Tx_Serial_out <= tx_byte[bit_idx + 3'd1];
                        end else begin
                            bit_idx       <= '0;
                            Tx_Serial_out <= 1'b1;
                            state         <= STOP;
                        end
                    end
                end

                STOP: begin
                    // Done and the fall of Active land on the final cycle of the stop bit.
                    if (clk_cnt == PRE_LAST_CNT) begin
                        Tx_Done_out   <= 1'b1;
                        Tx_Active_out <= 1'b0;
                    end
                    if (clk_cnt != LAST_CNT) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        state   <= CLEANUP;
                    end
                end

                CLEANUP: begin
                    Tx_Serial_out <= 1'b1;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: a 868-clock instance and a 4-clock instance checked every cycle
// against a timeline model of the 8N1 frame, plus bit-centre decoding and literal timing checks.
module tb_transmitter;

    localparam int N_A = 868;
    localparam int N_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, dv_a, dv_b;
    logic [7:0] byte_a, byte_b;
    logic       act_a, ser_a, dn_a, act_b, ser_b, dn_b;

    transmitter #(.CLKS_PER_BIT(N_A)) dut_a (
        .CLK(clk), .RST(rst_a), .Tx_DV_in(dv_a), .Tx_Byte_in(byte_a),
        .Tx_Active_out(act_a), .Tx_Serial_out(ser_a), .Tx_Done_out(dn_a)
    );

    transmitter #(.CLKS_PER_BIT(N_B)) dut_b (
        .CLK(clk), .RST(rst_b), .Tx_DV_in(dv_b), .Tx_Byte_in(byte_b),
        .Tx_Active_out(act_b), .Tx_Serial_out(ser_b), .Tx_Done_out(dn_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: frame time t counts cycles since the accepting edge; t == 10n is the cleanup cycle.
    bit         m_busy [2] = '{0, 0};
    int         m_t    [2] = '{0, 0};
    logic [7:0] m_byte [2] = '{8'h00, 8'h00};

    // Observed-line bookkeeping used by the literal checks.
    int   done_cnt  [2] = '{0, 0};
    int   done_cyc  [2] = '{0, 0};
    int   done_viol [2] = '{0, 0};
    int   fall_cyc  [2] = '{0, 0};
    int   low_run   [2] = '{0, 0};
    int   last_low  [2] = '{0, 0};
    logic prev_ser  [2] = '{1'b1, 1'b1};
    logic prev_done [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic int nbit(input int w);
        return (w == 0) ? N_A : N_B;
    endfunction

    // {active, serial, done}
    function automatic logic [2:0] outs(input int w);
        return (w == 0) ? {act_a, ser_a, dn_a} : {act_b, ser_b, dn_b};
    endfunction

    function automatic logic rst_of(input int w);
        return (w == 0) ? rst_a : rst_b;
    endfunction

    function automatic logic [2:0] expect_out(input int w);
        int   n;
        int   t;
        int   slot;
        logic ser;
        n = nbit(w);
        t = m_t[w];
        if (!m_busy[w] || t >= 10 * n) return 3'b010;
        slot = t / n;
        if (slot == 0)      ser = 1'b0;
        else if (slot <= 8) ser = m_byte[w][slot - 1];
        else                ser = 1'b1;
        return {(t < 10 * n - 1), ser, (t == 10 * n - 1)};
    endfunction

    task automatic model_step(input int w, input logic r, input logic d, input logic [7:0] b);
        if (r) begin
            m_busy[w] = 1'b0;
        end else if (m_busy[w]) begin
            if (m_t[w] == 10 * nbit(w)) m_busy[w] = 1'b0;
            else                        m_t[w]++;
        end else if (d) begin
            m_busy[w] = 1'b1;
            m_t[w]    = 0;
            m_byte[w] = b;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0, rst_a, dv_a, byte_a);
        model_step(1, rst_b, dv_b, byte_b);
        cyc++;
    end

    // Compare process: every cycle, both instances, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            logic [2:0] o;
            logic [2:0] e;
            o = outs(w);
            e = rst_of(w) ? 3'b010 : expect_out(w);
            check((w == 0) ? "line_a" : "line_b", 32'(o), 32'(e));
            if (o[0]) begin
                done_cnt[w]++;
                if (prev_done[w]) done_viol[w]++;
                else              done_cyc[w] = cyc;
            end
            prev_done[w] = o[0];
            if (!o[1]) begin
                if (prev_ser[w]) fall_cyc[w] = cyc;
                low_run[w]++;
            end else begin
                if (!prev_ser[w]) last_low[w] = low_run[w];
                low_run[w] = 0;
            end
            prev_ser[w] = o[1];
        end
    end

    task automatic set_in(input int w, input logic d, input logic [7:0] b);
        if (w == 0) begin
            dv_a = d; byte_a = b;
        end else begin
            dv_b = d; byte_b = b;
        end
    endtask

    // One-cycle strobe; t0 is the cycle index of the accepting edge.
    task automatic send(input int w, input logic [7:0] b, output int t0);
        logic [2:0] o;
        @(posedge clk); #1;
        o = outs(w);
        check("active_low_before_send", 32'(o[2]), 32'd0);
        set_in(w, 1'b1, b);
        @(posedge clk); #1;
        t0 = cyc;
        set_in(w, 1'b0, 8'h00);
        o = outs(w);
        check("active_rise_after_dv", 32'(o[2]), 32'd1);
    endtask

    // Receiver sampling at bit centres after the start edge.
    task automatic recv(input int w, output logic [7:0] b, output logic stop_bit, output int low_w);
        int         n;
        int         k;
        logic [2:0] o;
        n = nbit(w);
        k = 0;
        b = '0;
        stop_bit = 1'b0;
        low_w = 0;
        do begin
            @(negedge clk);
            k++;
            o = outs(w);
        end while (o[1] !== 1'b0 && k < 20 * n);
        check("start_edge_seen", 32'(k < 20 * n), 32'd1);
        if (k >= 20 * n) return;
        repeat (n / 2) @(negedge clk);
        o = outs(w);
        check("start_bit_centre", 32'(o[1]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (n) @(negedge clk);
            o = outs(w);
            b[i] = o[1];
            if (i == 0) low_w = last_low[w];
        end
        repeat (n) @(negedge clk);
        o = outs(w);
        stop_bit = o[1];
    endtask

    task automatic wait_done(input int w, input int dc0);
        int k;
        k = 0;
        while (done_cnt[w] == dc0 && k < 12 * nbit(w)) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_seen", 32'(done_cnt[w] > dc0), 32'd1);
    endtask

    task automatic seq_a();
        logic [7:0] bytes [3] = '{8'h61, 8'h62, 8'h63};
        logic [7:0] b;
        logic       stop_bit;
        int         low_w, t0, dc0, lows;
        logic [2:0] o;
        for (int f = 0; f < 3; f++) begin
            dc0 = done_cnt[0];
            send(0, bytes[f], t0);
            recv(0, b, stop_bit, low_w);
            check("a_decoded_byte", 32'(b), 32'(bytes[f]));
            check("a_stop_bit", 32'(stop_bit), 32'd1);
            if (bytes[f][0]) check("a_start_low_width", 32'(low_w), 32'd868);
            wait_done(0, dc0);
            check("a_done_latency", 32'(done_cyc[0] - t0), 32'd8679);
            lows = 0;
            repeat (200) begin
                @(negedge clk); #1;
                o = outs(0);
                if (!o[1]) lows++;
            end
            check("a_line_high_between_frames", 32'(lows), 32'd0);
            check("a_single_done_per_frame", 32'(done_cnt[0] - dc0), 32'd1);
        end
    endtask

    task automatic seq_b();
        logic [7:0] b;
        logic       stop_bit;
        int         low_w, t0, dc0, k;
        logic [2:0] o;

        // Single 0x80 frame on the 4-clock instance.
        dc0 = done_cnt[1];
        send(1, 8'h80, t0);
        recv(1, b, stop_bit, low_w);
        check("b_decoded_0x80", 32'(b), 32'h80);
        check("b_stop_bit", 32'(stop_bit), 32'd1);
        wait_done(1, dc0);
        check("b_frame_length", 32'(done_cyc[1] - t0 + 1), 32'd40);
        repeat (10) @(negedge clk);

        // Strobe with 0xFF in the middle of a 0x00 frame must be ignored.
        dc0 = done_cnt[1];
        send(1, 8'h00, t0);
        fork
            recv(1, b, stop_bit, low_w);
            begin
                repeat (15) @(posedge clk);
                #1 set_in(1, 1'b1, 8'hFF);
                @(posedge clk);
                #1 set_in(1, 1'b0, 8'hFF);
            end
        join
        check("b_midframe_dv_ignored", 32'(b), 32'h00);
        wait_done(1, dc0);
        repeat (60) @(negedge clk);
        #1;
        o = outs(1);
        check("b_no_second_frame", 32'(done_cnt[1] - dc0), 32'd1);
        check("b_idle_after_ignored_dv", 32'(o), 32'b010);

        // Reset during data bit 3 (bit 3 of 0x35 is 0, so the line must jump high).
        dc0 = done_cnt[1];
        send(1, 8'h35, t0);
        repeat (17) @(posedge clk);
        #2 rst_b = 1'b1;
        #1;
        o = outs(1);
        check("b_reset_forces_idle", 32'(o), 32'b010);
        @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check("b_no_done_after_abort", 32'(done_cnt[1] - dc0), 32'd0);
        send(1, 8'hA5, t0);
        recv(1, b, stop_bit, low_w);
        check("b_decoded_after_reset", 32'(b), 32'hA5);
        wait_done(1, dc0);
        repeat (10) @(negedge clk);

        // Strobe held high: next frame starts on the first IDLE cycle after CLEANUP.
        dc0 = done_cnt[1];
        @(posedge clk);
        #1 set_in(1, 1'b1, 8'h5A);
        wait_done(1, dc0);
        k = 0;
        while (fall_cyc[1] <= done_cyc[1] && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        check("b_back_to_back_gap", 32'(fall_cyc[1] - done_cyc[1]), 32'd3);
        set_in(1, 1'b0, 8'h00);
        wait_done(1, dc0 + 1);
        repeat (10) @(negedge clk);

        // Random strobes, bytes and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            set_in(1, ($urandom_range(0, 3) == 0), 8'($urandom));
            rst_b = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #1;
        set_in(1, 1'b0, 8'h00);
        rst_b = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        logic [2:0] o;
        rst_a = 1'b1; rst_b = 1'b1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        #2;
        o = outs(0);
        check("a_reset_state", 32'(o), 32'b010);
        o = outs(1);
        check("b_reset_state", 32'(o), 32'b010);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        check("a_done_never_two_cycles", 32'(done_viol[0]), 32'd0);
        check("b_done_never_two_cycles", 32'(done_viol[1]), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
